axil_regbank: RTL and testbench
===============================

Name: axil_regbank

Overview:
- Parametrised AXI4-Lite slave register bank; next generation of the fixed 4 x 32-bit S00_AXI slave in subsystem_v1_1.
- Generalised in data width, address width and register count. Adds byte-strobe writes, independent AW/W acceptance and range-checked responses.
- Exposes every register and a per-register write pulse to fabric logic.
- Sits behind the subsystem interconnect. Targeted by the master VIP in the subsystem bench.

Parameters:
DATA_WIDTH, 32, AXI data width; 32 or 64 only.
ADDR_WIDTH, 6, AXI address width; must be >= ADDR_LSB + clog2(NUM_REGS).
NUM_REGS, 4, number of read/write registers; 1..256.
RESET_VAL, 0, reset value loaded into every register (DATA_WIDTH bits).

Ports:
ACLK  in  1  clock, all logic on rising edge
ARESET  in  1  synchronous, active-high reset
S_AXI_AWADDR  in  ADDR_WIDTH  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_WDATA  in  DATA_WIDTH  write data
S_AXI_WSTRB  in  DATA_WIDTH/8  byte strobes
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data ready
S_AXI_BRESP  out  2  write response
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_ARADDR  in  ADDR_WIDTH  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address ready
S_AXI_RDATA  out  DATA_WIDTH  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data ready
reg_q  out  NUM_REGS*DATA_WIDTH  register contents; reg i at [i*DATA_WIDTH +: DATA_WIDTH]
reg_wr_pulse  out  NUM_REGS  one-cycle pulse on the cycle reg i is committed

Behaviour:
- Reset (ARESET=1 at a rising edge):
  - All READY, VALID, RESP, RDATA outputs and reg_wr_pulse go to 0.
  - Every register takes RESET_VAL.
  - Pending AW/W holds and in-flight B/R are discarded; no commit occurs.
  - READYs rise in the first cycle after ARESET deasserts.
- Decode:
  - ADDR_LSB = clog2(DATA_WIDTH/8).
  - index = ADDR[ADDR_WIDTH-1:ADDR_LSB]; low address bits ignored.
  - In range iff index < NUM_REGS.
- Write FSM, WR_COLLECT -> WR_RESP -> WR_COLLECT:
  - WR_COLLECT: AWREADY=1 while no AW held; WREADY=1 while no W held. AW and W accepted independently, in either order or the same cycle, each captured into its own holding register.
  - The edge that completes the later handshake, or both together, moves to WR_RESP.
  - Entering WR_RESP: BVALID=1. If in range: bytes with WSTRB[k]=1 are written to the register, reg_wr_pulse[index]=1 for exactly that cycle, and reg_q shows the new value in that same cycle.
  - Out of range: no register changes and no pulse.
  - WR_RESP: AWREADY=WREADY=0. BVALID and BRESP hold until BREADY. The BVALID&BREADY edge returns to WR_COLLECT.
  - WSTRB=0 with in-range address: the pulse still fires and data is unchanged.
- Read FSM, RD_IDLE -> RD_DATA -> RD_IDLE:
  - RD_IDLE: ARREADY=1.
  - AR handshake edge: RDATA is loaded from the register value before that edge. A write committing on the same edge is not visible. RVALID=1 next cycle.
  - Out-of-range read: RDATA=0.
  - RD_DATA: ARREADY=0. RDATA, RRESP and RVALID hold until RREADY. The handshake edge returns to RD_IDLE.
  - Peak read rate is one read per 2 cycles.
- Read and write FSMs are fully independent; simultaneous traffic on both is legal.
- RESP encoding: OKAY=2'b00, SLVERR=2'b10. Out-of-range RESP is set by the optional feature.
- One outstanding write and one outstanding read maximum. No IDs.

Optional Feature:
- Macro: AXIL_REGBANK_SLVERR_EN.
- Defined: out-of-range writes return BRESP=SLVERR; out-of-range reads return RRESP=SLVERR with RDATA=0.
- Undefined: out-of-range accesses return OKAY. Writes are silently dropped; reads return 0.
- In-range behaviour is identical in both builds.

Test Plan:
- Defaults. Write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, then read back -> each read returns the matching value with RRESP=OKAY; each write pulses reg_wr_pulse bit 0..3 once.
- Reg0=0x11223344, then write 0xAABBCCDD with WSTRB=4'b0101 to 0x0 -> reg_q[31:0]=0x11BB33DD.
- W presented 3 cycles before AW to 0x8 with data 0x55 -> WREADY drops after W capture, AW accepted later. BVALID appears the cycle after the AW handshake; reg2=0x55.
- Write 0x10 (index 4, NUM_REGS=4), then read 0x10 -> all registers unchanged; RDATA=0. RESP=SLVERR with AXIL_REGBANK_SLVERR_EN defined, OKAY without.
- Hold BREADY=0 for 10 cycles after a write -> BVALID stays 1, AWREADY/WREADY stay 0, and a second AW is not accepted until the B handshake.
- Assert ARESET for 1 cycle with AW captured and W pending -> no commit, BVALID=0, all registers = RESET_VAL, READYs high the next cycle; DATA_WIDTH=64 rerun of the first scenario passes at 8-byte stride.

Source files
------------

// File: rtl/axil_regbank_if.sv
// axil_regbank_if: AXI4-Lite bus bundle (AW/W/B/AR/R channels) with master and slave modports
interface axil_regbank_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
);
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic [2:0]              AWPROT;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WVALID;
  logic                    WREADY;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic [2:0]              ARPROT;
  logic                    ARVALID;
  logic                    ARREADY;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RVALID;
  logic                    RREADY;
  modport master (
    output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARPROT, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
  modport slave (
    input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARPROT, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/axil_regbank.sv
// axil_regbank: AXI4-Lite slave register bank; ports ACLK/ARESET (sync active-high), S_AXI slave bus, reg_q contents, reg_wr_pulse commit pulses; AXIL_REGBANK_SLVERR_EN makes out-of-range accesses return SLVERR
module axil_regbank #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_REGS = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  axil_regbank_if.slave                  S_AXI,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            reg_wr_pulse
);
  localparam int STRB_W = DATA_WIDTH/8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W = ADDR_WIDTH - ADDR_LSB;
  localparam logic [IDX_W:0] NREGS = (IDX_W+1)'(NUM_REGS);
  localparam logic [1:0] OKAY = 2'b00;
`ifdef AXIL_REGBANK_SLVERR_EN
  localparam logic [1:0] OOR_RESP = 2'b10;
`else
  localparam logic [1:0] OOR_RESP = 2'b00;
`endif
  typedef enum logic {WR_COLLECT, WR_RESP} wr_state_e;
  typedef enum logic {RD_IDLE, RD_DATA} rd_state_e;
  wr_state_e wr_q, wr_d;
  rd_state_e rd_q, rd_d;
  logic aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d, w_addr;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, w_data;
  logic [STRB_W-1:0] wstrb_q, wstrb_d, w_strb;
  logic awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic arready_q, arready_d, rvalid_q, rvalid_d;
  logic [1:0] bresp_q, bresp_d, rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d, rd_val;
  logic [NUM_REGS*DATA_WIDTH-1:0] regs_q;
  logic [NUM_REGS-1:0] pulse_q, pulse_d;
  logic aw_hs, w_hs, ar_hs, commit;
  logic [IDX_W-1:0] w_idx, r_idx;
  logic unused_ok;
  assign aw_hs = S_AXI.AWVALID & awready_q;
  assign w_hs = S_AXI.WVALID & wready_q;
  assign ar_hs = S_AXI.ARVALID & arready_q;
  // A handshake on the completing edge commits straight from the bus, otherwise from the holding register
  assign w_addr = aw_held_q ? awaddr_q : S_AXI.AWADDR;
  assign w_data = w_held_q ? wdata_q : S_AXI.WDATA;
  assign w_strb = w_held_q ? wstrb_q : S_AXI.WSTRB;
  assign w_idx = w_addr[ADDR_WIDTH-1:ADDR_LSB];
  assign r_idx = S_AXI.ARADDR[ADDR_WIDTH-1:ADDR_LSB];
  assign unused_ok = ^{S_AXI.AWPROT, S_AXI.ARPROT, S_AXI.ARADDR[ADDR_LSB-1:0], w_addr[ADDR_LSB-1:0]};
  always_comb begin
    wr_d = wr_q;
    aw_held_d = aw_held_q | aw_hs;
    w_held_d = w_held_q | w_hs;
    awaddr_d = aw_hs ? S_AXI.AWADDR : awaddr_q;
    wdata_d = w_hs ? S_AXI.WDATA : wdata_q;
    wstrb_d = w_hs ? S_AXI.WSTRB : wstrb_q;
    bvalid_d = bvalid_q;
    bresp_d = bresp_q;
    commit = 1'b0;
    if (wr_q == WR_COLLECT && aw_held_d && w_held_d) begin
      commit = 1'b1;
      wr_d = WR_RESP;
      aw_held_d = 1'b0;
      w_held_d = 1'b0;
      bvalid_d = 1'b1;
      bresp_d = ({1'b0, w_idx} < NREGS) ? OKAY : OOR_RESP;
    end else if (wr_q == WR_RESP && S_AXI.BREADY) begin
      wr_d = WR_COLLECT;
      bvalid_d = 1'b0;
    end
    awready_d = wr_d == WR_COLLECT && !aw_held_d;
    wready_d = wr_d == WR_COLLECT && !w_held_d;
    for (int i = 0; i < NUM_REGS; i++) pulse_d[i] = commit && w_idx == IDX_W'(i);
  end
  // Unmatched indices fall through to zero, which is the out-of-range read data
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) if (r_idx == IDX_W'(i)) rd_val = regs_q[i*DATA_WIDTH +: DATA_WIDTH];
  end
  always_comb begin
    rd_d = rd_q;
    rvalid_d = rvalid_q;
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    if (ar_hs) begin
      rd_d = RD_DATA;
      rvalid_d = 1'b1;
      rdata_d = rd_val;
      rresp_d = ({1'b0, r_idx} < NREGS) ? OKAY : OOR_RESP;
    end else if (rd_q == RD_DATA && S_AXI.RREADY) begin
      rd_d = RD_IDLE;
      rvalid_d = 1'b0;
    end
    arready_d = rd_d == RD_IDLE;
  end
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_q <= WR_COLLECT;
      rd_q <= RD_IDLE;
      aw_held_q <= 1'b0;
      w_held_q <= 1'b0;
      awaddr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      awready_q <= 1'b0;
      wready_q <= 1'b0;
      bvalid_q <= 1'b0;
      bresp_q <= '0;
      arready_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q <= '0;
      rresp_q <= '0;
      pulse_q <= '0;
      regs_q <= {NUM_REGS{RESET_VAL}};
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      aw_held_q <= aw_held_d;
      w_held_q <= w_held_d;
      awaddr_q <= awaddr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      awready_q <= awready_d;
      wready_q <= wready_d;
      bvalid_q <= bvalid_d;
      bresp_q <= bresp_d;
      arready_q <= arready_d;
      rvalid_q <= rvalid_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
      pulse_q <= pulse_d;
      for (int i = 0; i < NUM_REGS; i++)
        for (int b = 0; b < STRB_W; b++)
          if (pulse_d[i] && w_strb[b]) regs_q[i*DATA_WIDTH + 8*b +: 8] <= w_data[8*b +: 8];
    end
  end
  assign S_AXI.AWREADY = awready_q;
  assign S_AXI.WREADY = wready_q;
  assign S_AXI.BVALID = bvalid_q;
  assign S_AXI.BRESP = bresp_q;
  assign S_AXI.ARREADY = arready_q;
  assign S_AXI.RVALID = rvalid_q;
  assign S_AXI.RDATA = rdata_q;
  assign S_AXI.RRESP = rresp_q;
  assign reg_q = regs_q;
  assign reg_wr_pulse = pulse_q;
endmodule

// File: tb/tb_axil_regbank.sv
// tb_axil_regbank: randomized self-checking bench for axil_regbank against an array-based register model
module tb_axil_regbank;
  localparam logic [31:0] RV = 32'hA5A5_0F0F;
  localparam logic [63:0] RV64 = 64'h0123_4567_89AB_CDEF;
`ifdef AXIL_REGBANK_SLVERR_EN
  localparam logic [1:0] OOR = 2'b10;
`else
  localparam logic [1:0] OOR = 2'b00;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [127:0] reg_q;
  logic [3:0] pulse;
  logic [255:0] reg_q64;
  logic [3:0] pulse64;
  logic [31:0] model [4];
  logic [63:0] model64 [4];
  int n_chk = 0;
  int n_pass = 0;
  always #5 clk = ~clk;
  axil_regbank_if #(.DATA_WIDTH(32), .ADDR_WIDTH(6)) bif ();
  axil_regbank_if #(.DATA_WIDTH(64), .ADDR_WIDTH(6)) bif64 ();
  axil_regbank #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .NUM_REGS(4), .RESET_VAL(RV)) dut (
    .ACLK(clk), .ARESET(rst), .S_AXI(bif.slave), .reg_q(reg_q), .reg_wr_pulse(pulse));
  axil_regbank #(.DATA_WIDTH(64), .ADDR_WIDTH(6), .NUM_REGS(4), .RESET_VAL(RV64)) dut64 (
    .ACLK(clk), .ARESET(rst), .S_AXI(bif64.slave), .reg_q(reg_q64), .reg_wr_pulse(pulse64));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic check_regs();
    for (int i = 0; i < 4; i++) check("reg_q", reg_q[i*32 +: 32], model[i]);
  endtask

  task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input int b_dly);
    int n = 0;
    int hs_n = -1;
    int idx = int'(a) / 4;
    bit aw_done = 0, w_done = 0, faw, fw;
    logic [3:0] exp_pulse = '0;
    bif.AWADDR = a;
    bif.WDATA = d;
    bif.WSTRB = s;
    bif.AWPROT = 3'($urandom);
    while (!bif.BVALID && n < 40) begin
      bif.AWVALID = !aw_done && n >= aw_dly;
      bif.WVALID = !w_done && n >= w_dly;
      faw = bif.AWVALID && bif.AWREADY;
      fw = bif.WVALID && bif.WREADY;
      @(posedge clk); #1;
      n++;
      aw_done |= faw;
      w_done |= fw;
      if (aw_done && w_done && hs_n < 0) hs_n = n;
      if (w_done && !aw_done) check("wready_held", bif.WREADY, 0);
      if (aw_done && !w_done) check("awready_held", bif.AWREADY, 0);
    end
    bif.AWVALID = 0;
    bif.WVALID = 0;
    check("b_latency", n, hs_n);
    if (idx < 4) begin
      for (int b = 0; b < 4; b++) if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
      exp_pulse[idx] = 1'b1;
    end
    check("bvalid", bif.BVALID, 1);
    check("bresp", bif.BRESP, idx < 4 ? 2'b00 : OOR);
    check("wr_pulse", pulse, exp_pulse);
    check_regs();
    for (int k = 0; k < b_dly; k++) begin
      bif.AWVALID = 1;
      @(posedge clk); #1;
      check("b_hold", {bif.BVALID, bif.AWREADY, bif.WREADY}, 3'b100);
      check("bresp_hold", bif.BRESP, idx < 4 ? 2'b00 : OOR);
    end
    bif.AWVALID = 0;
    bif.BREADY = 1;
    @(posedge clk); #1;
    bif.BREADY = 0;
    check("b_done", bif.BVALID, 0);
    check("pulse_clear", pulse, 0);
  endtask

  task automatic axi_read(input logic [5:0] a, input int r_dly);
    int n = 0;
    int idx = int'(a) / 4;
    bit far = 0;
    logic [31:0] exp = '0;
    bif.ARADDR = a;
    bif.ARPROT = 3'($urandom);
    bif.ARVALID = 1;
    while (!far && n < 40) begin
      far = bif.ARREADY;
      exp = idx < 4 ? model[idx] : 32'h0;
      @(posedge clk); #1;
      n++;
    end
    bif.ARVALID = 0;
    check("ar_accept", far, 1);
    check("rvalid", bif.RVALID, 1);
    check("rdata", bif.RDATA, exp);
    check("rresp", bif.RRESP, idx < 4 ? 2'b00 : OOR);
    for (int k = 0; k < r_dly; k++) begin
      @(posedge clk); #1;
      check("r_hold", {bif.RVALID, bif.ARREADY}, 2'b10);
      check("rdata_hold", bif.RDATA, exp);
    end
    bif.RREADY = 1;
    @(posedge clk); #1;
    bif.RREADY = 0;
    check("r_done", {bif.RVALID, bif.ARREADY}, 2'b01);
  endtask

  task automatic wr64(input logic [5:0] a, input logic [63:0] d);
    int n = 0;
    int idx = int'(a) / 8;
    bit fa = 0, fw = 0, ta, tw;
    bif64.AWADDR = a;
    bif64.WDATA = d;
    bif64.WSTRB = '1;
    while (!bif64.BVALID && n < 20) begin
      bif64.AWVALID = !fa;
      bif64.WVALID = !fw;
      ta = bif64.AWREADY;
      tw = bif64.WREADY;
      @(posedge clk); #1;
      n++;
      fa |= ta;
      fw |= tw;
    end
    bif64.AWVALID = 0;
    bif64.WVALID = 0;
    model64[idx] = d;
    check("bvalid64", bif64.BVALID, 1);
    check("wr_pulse64", pulse64, 64'(1) << idx);
    check("reg_q64", reg_q64[idx*64 +: 64], model64[idx]);
    bif64.BREADY = 1;
    @(posedge clk); #1;
    bif64.BREADY = 0;
  endtask

  task automatic rd64(input logic [5:0] a);
    int n = 0;
    bit far = 0;
    bif64.ARADDR = a;
    bif64.ARVALID = 1;
    while (!far && n < 20) begin
      far = bif64.ARREADY;
      @(posedge clk); #1;
      n++;
    end
    bif64.ARVALID = 0;
    check("rvalid64", bif64.RVALID, 1);
    check("rdata64", bif64.RDATA, model64[int'(a) / 8]);
    bif64.RREADY = 1;
    @(posedge clk); #1;
    bif64.RREADY = 0;
  endtask

  initial begin
    logic [31:0] old;
    {bif.AWADDR, bif.AWPROT, bif.AWVALID, bif.WDATA, bif.WSTRB, bif.WVALID, bif.BREADY} = '0;
    {bif.ARADDR, bif.ARPROT, bif.ARVALID, bif.RREADY} = '0;
    {bif64.AWADDR, bif64.AWPROT, bif64.AWVALID, bif64.WDATA, bif64.WSTRB, bif64.WVALID, bif64.BREADY} = '0;
    {bif64.ARADDR, bif64.ARPROT, bif64.ARVALID, bif64.RREADY} = '0;
    for (int i = 0; i < 4; i++) begin
      model[i] = RV;
      model64[i] = RV64;
    end
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {bif.AWREADY, bif.WREADY, bif.ARREADY}, 3'b000);
    check("rst_valid", {bif.BVALID, bif.RVALID}, 2'b00);
    check("rst_pulse", pulse, 0);
    check_regs();
    rst = 0;
    @(posedge clk); #1;
    check("ready_after_rst", {bif.AWREADY, bif.WREADY, bif.ARREADY}, 3'b111);
    for (int i = 0; i < 4; i++) axi_write(6'(4*i), 32'(i + 1), 4'hF, 0, 0, 0);
    for (int i = 0; i < 4; i++) axi_read(6'(4*i), 0);
    axi_write(6'h00, 32'h1122_3344, 4'hF, 0, 0, 0);
    axi_write(6'h00, 32'hAABB_CCDD, 4'b0101, 0, 0, 0);
    check("strb_reg0", reg_q[31:0], 32'h11BB_33DD);
    axi_write(6'h08, 32'h55, 4'hF, 3, 0, 0);
    check("late_aw_reg2", reg_q[95:64], 32'h55);
    axi_write(6'h10, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
    axi_read(6'h10, 0);
    axi_write(6'h04, 32'h0BAD_F00D, 4'hF, 0, 2, 10);
    axi_write(6'h0C, 32'h1234_5678, 4'h0, 1, 0, 0);
    check("same_edge_ready", {bif.AWREADY, bif.WREADY, bif.ARREADY}, 3'b111);
    old = model[1];
    bif.AWADDR = 6'h04;
    bif.WDATA = 32'hCAFE_0001;
    bif.WSTRB = 4'hF;
    bif.ARADDR = 6'h04;
    {bif.AWVALID, bif.WVALID, bif.ARVALID} = 3'b111;
    @(posedge clk); #1;
    {bif.AWVALID, bif.WVALID, bif.ARVALID} = 3'b000;
    model[1] = 32'hCAFE_0001;
    check("same_edge_rdata_old", bif.RDATA, old);
    check("same_edge_valids", {bif.BVALID, bif.RVALID}, 2'b11);
    check("same_edge_pulse", pulse, 4'b0010);
    check_regs();
    {bif.BREADY, bif.RREADY} = 2'b11;
    @(posedge clk); #1;
    {bif.BREADY, bif.RREADY} = 2'b00;
    check("same_edge_done", {bif.BVALID, bif.RVALID}, 2'b00);
    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 1) == 1)
        axi_write(6'($urandom_range(0, 23)), $urandom, 4'($urandom), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 2));
      else
        axi_read(6'($urandom_range(0, 23)), $urandom_range(0, 2));
    end
    bif.AWADDR = 6'h0C;
    bif.AWVALID = 1;
    @(posedge clk); #1;
    bif.AWVALID = 0;
    bif.WDATA = 32'hDEAD_DEAD;
    bif.WSTRB = 4'hF;
    bif.WVALID = 1;
    rst = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      model[i] = RV;
      model64[i] = RV64;
    end
    check("rst2_ready", {bif.AWREADY, bif.WREADY, bif.ARREADY}, 3'b000);
    check("rst2_bvalid", bif.BVALID, 0);
    check("rst2_pulse", pulse, 0);
    check_regs();
    check("rst2_reg64", reg_q64[191:128], RV64);
    bif.WVALID = 0;
    rst = 0;
    @(posedge clk); #1;
    check("rst2_ready_up", {bif.AWREADY, bif.WREADY, bif.ARREADY}, 3'b111);
    repeat (3) begin
      @(posedge clk); #1;
      check("rst2_no_commit", {bif.BVALID, pulse}, 5'b0);
    end
    check_regs();
    axi_read(6'h0C, 1);
    for (int i = 0; i < 4; i++) wr64(6'(8*i), 64'(i + 1) << 32 | 64'(i + 1));
    for (int i = 0; i < 4; i++) rd64(6'(8*i));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
